pc_redirect_ctrl: RTL and testbench

- Owns the fetch PC register of the pipelined RISC-V core and decides the next PC every cycle.
- Arbitrates between four sources: trap redirects from MEM, branch/JALR redirects resolved in EX, hazard stalls and instruction-memory backpressure, and sequential PC+4.
- Drives the IF/ID and ID/EX flush lines.
- Sequences post-reset boot hold and post-trap pipeline drain.

---
 rtl/rv_pc_pkg.sv | 19 +
 rtl/pc_target_calc.sv | 49 ++++
 rtl/pc_redirect_ctrl.sv | 151 +++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pc_pkg.sv
// rv_pc_pkg: shared types and constants for the fetch PC redirect logic.
//   pc_state_e  : controller FSM states (boot hold, normal run, post-trap drain)
//   PC_SEL_*    : ex_sel encodings for the two legal redirect target forms
//   INSN_BYTES  : sequential fetch increment
//   CNT_W       : width of the boot/drain cycle counter (covers 1..15 cycles)
package rv_pc_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } pc_state_e;

   localparam logic [1:0]  PC_SEL_REL = 2'b01;
   localparam logic [1:0]  PC_SEL_REG = 2'b10;
   localparam logic [31:0] INSN_BYTES = 32'd4;
   localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational redirect target for a taken EX control transfer.
//   ex_sel_i       : 01 = PC-relative (ex_pc + imm), 10 = register (rs1 + imm, bit0 cleared)
//   ex_pc_i        : PC of the instruction in EX
//   ex_imm_i       : sign-extended immediate
//   ex_rs1_i       : forwarded rs1 value
//   target_o       : computed target (32-bit modulo sum)
//   sel_valid_o    : ex_sel is one of the two legal encodings
//   misaligned_o   : target bit1 set, i.e. not 4-byte aligned
module pc_target_calc
   import rv_pc_pkg::*;
(
   input  logic [1:0]  ex_sel_i,
   input  logic [31:0] ex_pc_i,
   input  logic [31:0] ex_imm_i,
   input  logic [31:0] ex_rs1_i,
   output logic [31:0] target_o,
   output logic        sel_valid_o,
   output logic        misaligned_o
);

   logic [31:0] rel_sum;
   logic [31:0] reg_sum;

   assign rel_sum = ex_pc_i + ex_imm_i;
   assign reg_sum = (ex_rs1_i + ex_imm_i) & ~32'h1;

   always_comb begin
      target_o    = rel_sum;
      sel_valid_o = 1'b0;
      case (ex_sel_i)
         PC_SEL_REL: begin
            target_o    = rel_sum;
            sel_valid_o = 1'b1;
         end
         PC_SEL_REG: begin
            target_o    = reg_sum;
            sel_valid_o = 1'b1;
         end
         default: begin
            target_o    = rel_sum;
            sel_valid_o = 1'b0;
         end
      endcase
   end

   // Bit0 is either cleared (JALR) or always zero (even immediates), so only bit1 matters.
   assign misaligned_o = target_o[1];

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: owns the fetch PC and chooses the next PC every cycle.
//   Sources in priority order: MEM trap, EX branch/JALR redirect, stall/backpressure hold,
//   sequential PC+4. Drives IF/ID and ID/EX flushes (Mealy) and sequences boot hold and
//   post-trap drain.
//   Inputs : clk, rst_n, stall, imem_ready, ex_branch, ex_sel, ex_pc, ex_imm, ex_rs1,
//            trap_req, trap_vec
//   Outputs: pc, pc_valid, redirect_err (registered); flush_if_id, flush_id_ex (comb)
module pc_redirect_ctrl
   import rv_pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned BOOT_CYCLES  = 2,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        imem_ready,
   input  logic        ex_branch,
   input  logic [1:0]  ex_sel,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_rs1,
   input  logic        trap_req,
   input  logic [31:0] trap_vec,
   output logic [31:0] pc,
   output logic        pc_valid,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        redirect_err
);

   localparam logic [CNT_W-1:0] BootLoad  = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DrainLoad = CNT_W'(DRAIN_CYCLES - 1);

   pc_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      pc_q, pc_d;
   logic             pc_valid_q, pc_valid_d;
   logic             err_q, err_d;
   logic             flush;

   logic [31:0] target;
   logic        sel_valid;
   logic        misaligned;
   logic        hold;
   logic [31:0] seq_pc;

   pc_target_calc u_target_calc (
      .ex_sel_i     (ex_sel),
      .ex_pc_i      (ex_pc),
      .ex_imm_i     (ex_imm),
      .ex_rs1_i     (ex_rs1),
      .target_o     (target),
      .sel_valid_o  (sel_valid),
      .misaligned_o (misaligned)
   );

   assign hold   = stall | ~imem_ready;
   assign seq_pc = pc_q + INSN_BYTES;   // carry out discarded: 0xFFFF_FFFC wraps to 0

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pc_d       = pc_q;
      pc_valid_d = pc_valid_q;
      err_d      = 1'b0;
      flush      = 1'b0;

      case (state_q)
         BOOT: begin
            flush      = 1'b1;
            pc_valid_d = 1'b0;
            if (cnt_q == '0) begin
               state_d    = RUN;
               pc_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         RUN: begin
            pc_valid_d = 1'b1;
            if (trap_req) begin
               pc_d    = trap_vec;
               flush   = 1'b1;
               state_d = DRAIN;
               cnt_d   = DrainLoad;
            end else if (ex_branch && sel_valid) begin
               // Redirect wins over stall/backpressure; misaligned targets are still taken.
               pc_d  = target;
               flush = 1'b1;
               err_d = misaligned;
            end else begin
               err_d = ex_branch;   // taken branch with an illegal select
               if (!hold) begin
                  pc_d = seq_pc;
               end
            end
         end

         DRAIN: begin
            flush      = 1'b1;
            pc_valid_d = 1'b1;
            if (trap_req) begin
               pc_d  = trap_vec;
               cnt_d = DrainLoad;
            end else begin
               if (!hold) begin
                  pc_d = seq_pc;
               end
               if (cnt_q == '0) begin
                  state_d = RUN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         default: begin
            state_d    = BOOT;
            cnt_d      = BootLoad;
            pc_valid_d = 1'b0;
            flush      = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         cnt_q      <= BootLoad;
         pc_q       <= RESET_PC;
         pc_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         err_q      <= err_d;
      end
   end

   assign pc           = pc_q;
   assign pc_valid     = pc_valid_q;
   assign redirect_err = err_q;
   assign flush_if_id  = flush;
   assign flush_id_ex  = flush;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: scoreboard bench for pc_redirect_ctrl. A reference model predicts
// the registered outputs for each driven cycle; predictions are queued when stimulus is
// applied and popped/compared after the capturing edge. Mealy flushes are checked live.
module tb_pc_redirect_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int unsigned BOOT_N  = 2;
   localparam int unsigned DRAIN_N = 2;

   localparam int M_BOOT  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        imem_ready;
   logic        ex_branch;
   logic [1:0]  ex_sel;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic [31:0] ex_rs1;
   logic        trap_req;
   logic [31:0] trap_vec;
   logic [31:0] pc;
   logic        pc_valid;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        redirect_err;

   typedef struct packed {
      logic [31:0] pc;
      logic        valid;
      logic        err;
   } exp_t;

   exp_t exp_q[$];

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state
   int          m_state;
   int          m_cnt;
   logic [31:0] m_pc;

   pc_redirect_ctrl #(
      .RESET_PC     (RST_PC),
      .BOOT_CYCLES  (BOOT_N),
      .DRAIN_CYCLES (DRAIN_N)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .imem_ready   (imem_ready),
      .ex_branch    (ex_branch),
      .ex_sel       (ex_sel),
      .ex_pc        (ex_pc),
      .ex_imm       (ex_imm),
      .ex_rs1       (ex_rs1),
      .trap_req     (trap_req),
      .trap_vec     (trap_vec),
      .pc           (pc),
      .pc_valid     (pc_valid),
      .flush_if_id  (flush_if_id),
      .flush_id_ex  (flush_id_ex),
      .redirect_err (redirect_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_state = M_BOOT;
      m_cnt   = int'(BOOT_N) - 1;
      m_pc    = RST_PC;
   endtask

   // Drive one cycle of stimulus starting just after a negedge; returns at the next negedge.
   task automatic drive(input logic st, input logic rdy, input logic br, input logic [1:0] sel,
                        input logic [31:0] epc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic trp, input logic [31:0] tv);
      logic        sel_ok;
      logic [31:0] tgt;
      logic        exp_flush;
      exp_t        e;
      exp_t        got;

      stall = st; imem_ready = rdy; ex_branch = br; ex_sel = sel;
      ex_pc = epc; ex_imm = imm; ex_rs1 = rs1; trap_req = trp; trap_vec = tv;
      #1;

      sel_ok = (sel == 2'b01) || (sel == 2'b10);
      tgt    = (sel == 2'b10) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (epc + imm);

      if (m_state == M_RUN) exp_flush = trp || (br && sel_ok);
      else                  exp_flush = 1'b1;
      check_eq("flush_if_id", {31'b0, flush_if_id}, {31'b0, exp_flush});
      check_eq("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, exp_flush});

      e.err = 1'b0;
      if (m_state == M_BOOT) begin
         if (m_cnt == 0) m_state = M_RUN;
         else            m_cnt--;
      end else if (trp) begin
         m_pc    = tv;
         m_state = M_DRAIN;
         m_cnt   = int'(DRAIN_N) - 1;
      end else if (m_state == M_RUN && br && sel_ok) begin
         m_pc  = tgt;
         e.err = tgt[1];
      end else begin
         if (m_state == M_RUN) e.err = br;
         if (!(st || !rdy)) m_pc = m_pc + 32'd4;
         if (m_state == M_DRAIN) begin
            if (m_cnt == 0) m_state = M_RUN;
            else            m_cnt--;
         end
      end
      e.pc    = m_pc;
      e.valid = (m_state != M_BOOT);
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check_eq("pc", pc, got.pc);
      check_eq("pc_valid", {31'b0, pc_valid}, {31'b0, got.valid});
      check_eq("redirect_err", {31'b0, redirect_err}, {31'b0, got.err});
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic branch(input logic st, input logic [31:0] epc, input logic [31:0] imm);
      drive(st, 1'b1, 1'b1, 2'b01, epc, imm, '0, 1'b0, '0);
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0; imem_ready = 1'b1; ex_branch = 1'b0; ex_sel = 2'b00;
      ex_pc = '0; ex_imm = '0; ex_rs1 = '0; trap_req = 1'b0; trap_vec = '0;
      m_reset();

      // Reset state
      @(posedge clk); #1;
      check_eq("rst_pc", pc, RST_PC);
      check_eq("rst_valid", {31'b0, pc_valid}, 32'd0);
      check_eq("rst_err", {31'b0, redirect_err}, 32'd0);
      check_eq("rst_flush", {30'b0, flush_if_id, flush_id_ex}, 32'd3);
      @(negedge clk);
      rst_n = 1'b1;

      // Boot hold, then sequential fetch
      idle(BOOT_N + 2);
      check_eq("boot_seq_pc", pc, 32'h8);

      // PC-relative branch
      branch(1'b0, 32'h0000_00C0, 32'h40);
      check_eq("br_pc_100", pc, 32'h100);
      branch(1'b0, 32'h0000_00F8, 32'h40);
      check_eq("br_pc_138", pc, 32'h138);
      idle(1);
      check_eq("br_seq_13c", pc, 32'h13C);

      // JALR with misaligned target, then invalid select
      drive(1'b0, 1'b1, 1'b1, 2'b10, '0, 32'h2, 32'h2001, 1'b0, '0);
      check_eq("jalr_pc", pc, 32'h2002);
      check_eq("jalr_err", {31'b0, redirect_err}, 32'd1);
      idle(1);
      drive(1'b0, 1'b1, 1'b1, 2'b11, 32'h40, 32'h40, '0, 1'b0, '0);
      check_eq("badsel_pc", pc, 32'h200A);
      idle(1);

      // Stall vs redirect, plus backpressure
      branch(1'b0, 32'h100, 32'h100);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b0, '0);
      check_eq("stall_hold", pc, 32'h200);
      drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0, '0);
      branch(1'b1, 32'h200, 32'h100);
      check_eq("stall_redirect", pc, 32'h300);

      // Trap beats a same-cycle branch; drain ignores the following branch
      drive(1'b0, 1'b1, 1'b1, 2'b01, 32'h300, 32'h40, '0, 1'b1, 32'h80);
      check_eq("trap_pc", pc, 32'h80);
      branch(1'b0, 32'h300, 32'h100);
      check_eq("drain_ign_br", pc, 32'h84);
      idle(2);

      // Trap inside drain restarts the counter
      drive(1'b0, 1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b1, 32'h400);
      drive(1'b0, 1'b1, 1'b0, 2'b00, '0, '0, '0, 1'b1, 32'h80);
      idle(1);
      check_eq("drain_pc_84", pc, 32'h84);

      // Asynchronous reset while draining
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_pc", pc, RST_PC);
      check_eq("arst_valid", {31'b0, pc_valid}, 32'd0);
      check_eq("arst_flush", {31'b0, flush_if_id}, 32'd1);
      m_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(BOOT_N + 1);

      // Wrap at top of address space
      branch(1'b0, 32'h0, 32'hFFFF_FFFC);
      idle(1);
      check_eq("wrap_pc", pc, 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 200; i++) begin
         drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
               $urandom() & 32'hFFFF_FFFC, $urandom() & 32'h0000_0FFE, $urandom(),
               ($urandom_range(0, 15) == 0), $urandom() & 32'hFFFF_FFFC);
      end

      if (exp_q.size() != 0) check_eq("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
